// File: rtl/instr_fsm_pkg.sv
// Shared constants and types for the instruction controller: opcode/op
// encodings, ALU operation codes, write-back select encodings, the
// controller state enum and the instruction-class flags from the decoder.
package instr_fsm_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_RA_W   = 3;

    // Primary opcode field ir[15:13]
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // Secondary op field ir[12:11] under OPC_MOV
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;

    // ALU operations; under OPC_ALU the op field maps directly onto these
    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_AND = 2'b10;
    localparam logic [1:0] ALUOP_NOT = 2'b11;

    // Write-back source select
    localparam logic VSEL_C   = 1'b0;
    localparam logic VSEL_IMM = 1'b1;

    typedef enum logic [2:0] {
        WAIT      = 3'd0,
        DECODE    = 3'd1,
        WRITE_IMM = 3'd2,
        GET_A     = 3'd3,
        GET_B     = 3'd4,
        ALU       = 3'd5,
        WRITE_REG = 3'd6,
        TRAP      = 3'd7
    } state_t;

    // Instruction classes; an instruction with none of these set is illegal.
    typedef struct packed {
        logic mov_imm;  // MOV Rn,#imm8
        logic mov_reg;  // MOV Rd,Rm{,sh}
        logic b_only;   // MOV reg or MVN: A operand forced to zero, skip GET_A
        logic two_op;   // ADD / CMP / AND: both operands read
        logic is_cmp;   // CMP: update status only, no write-back
    } iclass_t;

endpackage

// File: rtl/instr_fsm_ctrl_if.sv
// Bundle between the instruction source and the controller, plus the
// controller's datapath control outputs. master = instruction source,
// slave = instr_fsm_ctrl.
interface instr_fsm_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int RA_W   = 3
);
    logic              s;
    logic [DATA_W-1:0] instr;
    logic              w;
    logic [RA_W-1:0]   readnum;
    logic [RA_W-1:0]   writenum;
    logic              write;
    logic              vsel;
    logic              loada;
    logic              loadb;
    logic              asel;
    logic              loadc;
    logic              loads;
    logic [1:0]        ALUop;
    logic [1:0]        shift;
    logic [DATA_W-1:0] sximm8;
    logic              err;

    modport master (
        output s, instr,
        input  w, readnum, writenum, write, vsel, loada, loadb, asel,
               loadc, loads, ALUop, shift, sximm8, err
    );

    modport slave (
        input  s, instr,
        output w, readnum, writenum, write, vsel, loada, loadb, asel,
               loadc, loads, ALUop, shift, sximm8, err
    );
endinterface

// File: rtl/instr_dec.sv
// Combinational instruction decode: field extraction from the held
// instruction register, instruction-class flags and imm8 sign extension.
module instr_dec
    import instr_fsm_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RA_W   = 3
) (
    input  logic [DATA_W-1:0] ir,
    output logic [RA_W-1:0]   rn,
    output logic [RA_W-1:0]   rd,
    output logic [RA_W-1:0]   rm,
    output logic [1:0]        sh,
    output logic [1:0]        op,
    output logic [DATA_W-1:0] sximm8,
    output iclass_t           cls
);
    logic [2:0] opcode;
    logic       is_mov;
    logic       is_alu;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = RA_W'(ir[10:8]);
    assign rd     = RA_W'(ir[7:5]);
    assign sh     = ir[4:3];
    assign rm     = RA_W'(ir[2:0]);
    assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};

    assign is_mov = (opcode == OPC_MOV);
    assign is_alu = (opcode == OPC_ALU);

    // Class flags; every op value under OPC_ALU is legal, only two under OPC_MOV
    always_comb begin
        cls         = '0;
        cls.mov_imm = is_mov && (op == OP_MOV_IMM);
        cls.mov_reg = is_mov && (op == OP_MOV_REG);
        cls.b_only  = cls.mov_reg || (is_alu && (op == ALUOP_NOT));
        cls.two_op  = is_alu && (op != ALUOP_NOT);
        cls.is_cmp  = is_alu && (op == ALUOP_SUB);
    end
endmodule

// File: rtl/instr_fsm_ctrl.sv
// Multi-cycle instruction controller sitting in front of the ALU and its
// A/B/C/status registers. Captures an instruction on the start handshake
// and steps read, operand load, ALU and write-back one state per cycle.
// All control outputs are registered and reflect the current state.
//
// Build option: define ILLEGAL_TRAP_EN to lock up in TRAP (err=1) on an
// illegal instruction; otherwise illegal instructions act as a one-cycle
// NOP and err is constant 0.
//
// state     | meaning
// ----------+------------------------------------------------------------
// WAIT      | idle, w=1; s accepted here and instr captured into ir
// DECODE    | classify ir, no control output active
// WRITE_IMM | write sximm8 to Rn
// GET_A     | read Rn, load A
// GET_B     | read Rm, load B (shift applied on the B path)
// ALU       | drive ALUop; load C, or status only for CMP
// WRITE_REG | write C to Rd
// TRAP      | illegal instruction seen, err=1, held until reset
module instr_fsm_ctrl
    import instr_fsm_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RA_W   = DEF_RA_W
) (
    input  logic           clk,
    input  logic           reset_n,
    instr_fsm_ctrl_if.slave bus
);
    state_t            state;
    logic [DATA_W-1:0] ir;

    logic [RA_W-1:0]   rn;
    logic [RA_W-1:0]   rd;
    logic [RA_W-1:0]   rm;
    logic [1:0]        sh;
    logic [1:0]        op;
    logic [DATA_W-1:0] sximm8;
    iclass_t           cls;

    instr_dec #(
        .DATA_W (DATA_W),
        .RA_W   (RA_W)
    ) u_dec (
        .ir     (ir),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .sh     (sh),
        .op     (op),
        .sximm8 (sximm8),
        .cls    (cls)
    );

    assign bus.sximm8 = sximm8;

`ifndef ILLEGAL_TRAP_EN
    assign bus.err = 1'b0;
`endif

    // State register and registered control outputs. Each branch sets the
    // outputs belonging to the state being entered; anything not set falls
    // back to the inactive default at the top of the clocked branch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= WAIT;
            ir           <= '0;
            bus.w        <= 1'b1;
            bus.readnum  <= '0;
            bus.writenum <= '0;
            bus.write    <= 1'b0;
            bus.vsel     <= VSEL_C;
            bus.loada    <= 1'b0;
            bus.loadb    <= 1'b0;
            bus.asel     <= 1'b0;
            bus.loadc    <= 1'b0;
            bus.loads    <= 1'b0;
            bus.ALUop    <= ALUOP_ADD;
            bus.shift    <= 2'b00;
`ifdef ILLEGAL_TRAP_EN
            bus.err      <= 1'b0;
`endif
        end else begin
            bus.w        <= 1'b0;
            bus.readnum  <= '0;
            bus.writenum <= '0;
            bus.write    <= 1'b0;
            bus.vsel     <= VSEL_C;
            bus.loada    <= 1'b0;
            bus.loadb    <= 1'b0;
            bus.asel     <= 1'b0;
            bus.loadc    <= 1'b0;
            bus.loads    <= 1'b0;
            bus.ALUop    <= ALUOP_ADD;
            bus.shift    <= 2'b00;
`ifdef ILLEGAL_TRAP_EN
            bus.err      <= 1'b0;
`endif
            unique case (state)
                WAIT: begin
                    if (bus.s) begin
                        ir    <= bus.instr;
                        state <= DECODE;
                    end else begin
                        bus.w <= 1'b1;
                    end
                end

                DECODE: begin
                    if (cls.mov_imm) begin
                        state        <= WRITE_IMM;
                        bus.writenum <= rn;
                        bus.vsel     <= VSEL_IMM;
                        bus.write    <= 1'b1;
                    end else if (cls.b_only) begin
                        state       <= GET_B;
                        bus.readnum <= rm;
                        bus.loadb   <= 1'b1;
                        bus.shift   <= sh;
                    end else if (cls.two_op) begin
                        state       <= GET_A;
                        bus.readnum <= rn;
                        bus.loada   <= 1'b1;
                    end else begin
`ifdef ILLEGAL_TRAP_EN
                        state   <= TRAP;
                        bus.err <= 1'b1;
`else
                        state <= WAIT;
                        bus.w <= 1'b1;
`endif
                    end
                end

                GET_A: begin
                    state       <= GET_B;
                    bus.readnum <= rm;
                    bus.loadb   <= 1'b1;
                    bus.shift   <= sh;
                end

                GET_B: begin
                    // MOV reg reuses the adder with A forced to zero
                    state     <= ALU;
                    bus.ALUop <= cls.mov_reg ? ALUOP_ADD : op;
                    bus.asel  <= cls.b_only;
                    bus.shift <= sh;
                    if (cls.is_cmp) begin
                        bus.loads <= 1'b1;
                    end else begin
                        bus.loadc <= 1'b1;
                    end
                end

                ALU: begin
                    if (cls.is_cmp) begin
                        state <= WAIT;
                        bus.w <= 1'b1;
                    end else begin
                        state        <= WRITE_REG;
                        bus.writenum <= rd;
                        bus.vsel     <= VSEL_C;
                        bus.write    <= 1'b1;
                    end
                end

                WRITE_IMM, WRITE_REG: begin
                    state <= WAIT;
                    bus.w <= 1'b1;
                end

                TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                    state   <= TRAP;
                    bus.err <= 1'b1;
`else
                    state <= WAIT;
                    bus.w <= 1'b1;
`endif
                end

                default: begin
                    state <= WAIT;
                    bus.w <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fsm_ctrl.sv
// Self-checking bench for instr_fsm_ctrl. A behavioural model expands each
// accepted instruction into the list of per-cycle control vectors it must
// produce; a compare process checks the DUT against the model every cycle.
// Directed sequences add literal expectations; a random phase follows.
module tb_instr_fsm_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    instr_fsm_ctrl_if #(.DATA_W(16), .RA_W(3)) bus ();

    instr_fsm_ctrl #(.DATA_W(16), .RA_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       vsel;
        logic       loada;
        logic       loadb;
        logic       asel;
        logic       loadc;
        logic       loads;
        logic [1:0] aluop;
        logic [1:0] shift;
        logic       err;
    } vec_t;

    vec_t        q[$];
    vec_t        cur;
    logic [15:0] ir_m;
    bit          trapped;

    function automatic vec_t idle_v();
        vec_t v = '0;
        v.w = 1'b1;
        return v;
    endfunction

    function automatic vec_t trap_v();
        vec_t v = '0;
        v.err = 1'b1;
        return v;
    endfunction

    function automatic bit is_legal(logic [15:0] i);
        return (i[15:13] == 3'b110 && (i[12:11] == 2'b10 || i[12:11] == 2'b00))
            || (i[15:13] == 3'b101);
    endfunction

    // Expand one instruction into its busy-cycle output list
    function automatic void plan(logic [15:0] i);
        vec_t v;
        logic [1:0] op = i[12:11];
        bit is_mov = (i[15:13] == 3'b110);
        bit skip_a = is_mov || (op == 2'b11);
        bit is_cmp = !is_mov && (op == 2'b01);
        q.push_back('0);
        if (!is_legal(i)) begin
`ifdef ILLEGAL_TRAP_EN
            trapped = 1'b1;
`endif
            return;
        end
        if (is_mov && op == 2'b10) begin
            v = '0; v.writenum = i[10:8]; v.vsel = 1'b1; v.write = 1'b1;
            q.push_back(v);
            return;
        end
        if (!skip_a) begin
            v = '0; v.readnum = i[10:8]; v.loada = 1'b1;
            q.push_back(v);
        end
        v = '0; v.readnum = i[2:0]; v.loadb = 1'b1; v.shift = i[4:3];
        q.push_back(v);
        v = '0; v.aluop = is_mov ? 2'b00 : op; v.asel = skip_a; v.shift = i[4:3];
        if (is_cmp) v.loads = 1'b1; else v.loadc = 1'b1;
        q.push_back(v);
        if (!is_cmp) begin
            v = '0; v.writenum = i[7:5]; v.write = 1'b1;
            q.push_back(v);
        end
    endfunction

    // Reference model: cur holds the vector the DUT must show this cycle
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            cur = idle_v();
            trapped = 1'b0;
            ir_m = 16'h0000;
        end else if (cur.w && bus.s) begin
            ir_m = bus.instr;
            plan(bus.instr);
            cur = q.pop_front();
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else if (trapped) begin
            cur = trap_v();
        end else begin
            cur = idle_v();
        end
    end

    function automatic vec_t actual_v();
        vec_t a;
        a.w = bus.w; a.readnum = bus.readnum; a.writenum = bus.writenum;
        a.write = bus.write; a.vsel = bus.vsel; a.loada = bus.loada;
        a.loadb = bus.loadb; a.asel = bus.asel; a.loadc = bus.loadc;
        a.loads = bus.loads; a.aluop = bus.ALUop; a.shift = bus.shift;
        a.err = bus.err;
        return a;
    endfunction

    // Per-cycle comparison against the model, on the falling edge
    always @(negedge clk) begin
        vec_t a;
        logic [15:0] sx;
        a = actual_v();
        sx = 16'($signed(ir_m[7:0]));
        checks++;
        if (a !== cur) begin
            failures++;
            $display("FAIL cycle_vec t=%0t actual=%h expected=%h", $time, a, cur);
        end
        checks++;
        if (bus.sximm8 !== sx) begin
            failures++;
            $display("FAIL sximm8 t=%0t actual=%h expected=%h", $time, bus.sximm8, sx);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n_busy, n_loada, n_loadb, n_loadc, n_loads, n_write, n_asel, n_err;
    logic [2:0]  rd_a, rd_b, wn_w;
    logic [1:0]  aop, sh_b;
    logic        vsel_w;
    logic [15:0] sx_w;

    task automatic sample();
        if (bus.loada) begin n_loada++; rd_a = bus.readnum; end
        if (bus.loadb) begin n_loadb++; rd_b = bus.readnum; sh_b = bus.shift; end
        if (bus.loadc || bus.loads) aop = bus.ALUop;
        if (bus.loadc) n_loadc++;
        if (bus.loads) n_loads++;
        if (bus.asel) n_asel++;
        if (bus.write) begin
            n_write++; wn_w = bus.writenum; vsel_w = bus.vsel; sx_w = bus.sximm8;
        end
        if (bus.err) n_err++;
    endtask

    // Issue one instruction from WAIT and record its busy period (bounded)
    task automatic run(input logic [15:0] i, input bit hold_s);
        bus.s = 1'b1;
        bus.instr = i;
        tick();
        if (!hold_s) bus.s = 1'b0;
        n_busy = 0; n_loada = 0; n_loadb = 0; n_loadc = 0; n_loads = 0;
        n_write = 0; n_asel = 0; n_err = 0;
        rd_a = 'x; rd_b = 'x; wn_w = 'x; aop = 'x; sh_b = 'x; vsel_w = 'x; sx_w = 'x;
        while (!bus.w && n_busy < 12) begin
            n_busy++;
            sample();
            tick();
        end
    endtask

    function automatic logic [15:0] gen_instr();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom % 6)
            0: r[15:11] = 5'b11010;
            1: r[15:11] = 5'b11000;
            2, 3, 5: r[15:13] = 3'b101;
            default: ;
        endcase
`ifdef ILLEGAL_TRAP_EN
        if (!is_legal(r)) r[15:13] = 3'b101;
`endif
        return r;
    endfunction

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        cur = idle_v();
        bus.s = 1'b0;
        bus.instr = 16'h0000;
        repeat (3) tick();
        chk("reset_w", bus.w, 1);
        chk("reset_write", bus.write, 0);
        chk("reset_readnum", bus.readnum, 0);
        reset_n = 1'b1;
        tick();

        // MOV R5,#-1
        run(16'hD5FF, 1'b0);
        chk("movi_busy", n_busy, 2);
        chk("movi_write", n_write, 1);
        chk("movi_writenum", wn_w, 5);
        chk("movi_vsel", vsel_w, 1);
        chk("movi_sximm8", sx_w, 16'hFFFF);
        chk("movi_loada", n_loada, 0);

        // ADD R2,R1,R0
        run(16'hA140, 1'b0);
        chk("add_busy", n_busy, 5);
        chk("add_loada", n_loada, 1);
        chk("add_rd_a", rd_a, 1);
        chk("add_loadb", n_loadb, 1);
        chk("add_rd_b", rd_b, 0);
        chk("add_loadc", n_loadc, 1);
        chk("add_aluop", aop, 0);
        chk("add_write", n_write, 1);
        chk("add_writenum", wn_w, 2);

        // CMP R1,R0
        run(16'hA900, 1'b0);
        chk("cmp_busy", n_busy, 4);
        chk("cmp_loads", n_loads, 1);
        chk("cmp_loadc", n_loadc, 0);
        chk("cmp_aluop", aop, 1);
        chk("cmp_write", n_write, 0);

        // MVN R3,R0
        run(16'hB860, 1'b0);
        chk("mvn_busy", n_busy, 4);
        chk("mvn_asel", n_asel, 1);
        chk("mvn_aluop", aop, 3);
        chk("mvn_writenum", wn_w, 3);
        chk("mvn_loada", n_loada, 0);

        // MOV R4,R1,LSL#1 with s held: next instruction on first WAIT edge
        run(16'hC089, 1'b1);
        chk("movr_busy", n_busy, 4);
        chk("movr_rd_b", rd_b, 1);
        chk("movr_shift", sh_b, 1);
        chk("movr_asel", n_asel, 1);
        chk("movr_aluop", aop, 0);
        chk("movr_writenum", wn_w, 4);
        bus.instr = 16'hA140;
        chk("b2b_w_idle", bus.w, 1);
        tick();
        chk("b2b_no_bubble", bus.w, 0);
        bus.s = 1'b0;
        nb = 0;
        while (!bus.w && nb < 12) begin nb++; tick(); end
        chk("b2b_add_busy", nb, 5);

        // Asynchronous reset in the middle of GET_A
        bus.s = 1'b1;
        bus.instr = 16'hA140;
        tick();
        bus.s = 1'b0;
        tick();
        chk("rst_pre_loada", bus.loada, 1);
        chk("rst_pre_readnum", bus.readnum, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_async_w", bus.w, 1);
        chk("rst_async_loada", bus.loada, 0);
        chk("rst_async_readnum", bus.readnum, 0);
        tick();
        tick();
        reset_n = 1'b1;
        nb = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.write) nb++;
            tick();
        end
        chk("rst_no_write", nb, 0);
        chk("rst_idle_w", bus.w, 1);

        // Random traffic, with occasional asynchronous resets
        for (int k = 0; k < 3000; k++) begin
            bus.s = ($urandom % 3 == 0);
            bus.instr = gen_instr();
            if ($urandom % 400 == 0) begin
                reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
            tick();
        end
        bus.s = 1'b0;
        nb = 0;
        while (!bus.w && nb < 12) begin nb++; tick(); end
        chk("rand_drain_w", bus.w, 1);

        // Illegal instruction
        run(16'hE000, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        chk("trap_busy", n_busy, 12);
        chk("trap_err_cycles", n_err, 11);
        chk("trap_enables", n_loada + n_loadb + n_loadc + n_loads + n_write + n_asel, 0);
        nb = 0;
        for (int k = 0; k < 6; k++) begin
            bus.s = k[0];
            bus.instr = 16'hD5FF;
            tick();
            if (bus.w || !bus.err) nb++;
        end
        bus.s = 1'b0;
        chk("trap_sticky", nb, 0);
        reset_n = 1'b0;
        #1;
        chk("trap_reset_err", bus.err, 0);
        chk("trap_reset_w", bus.w, 1);
        tick();
        reset_n = 1'b1;
        tick();
`else
        chk("nop_busy", n_busy, 1);
        chk("nop_err", n_err, 0);
        chk("nop_enables", n_loada + n_loadb + n_loadc + n_loads + n_write + n_asel, 0);
        chk("nop_w", bus.w, 1);
`endif
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
